// File: rtl/image_blur_pkg.sv
// Shared types and constants for the streaming 3x3 Gaussian blur.
package image_blur_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 1-2-1 / 2-4-2 / 1-2-1 kernel weights
    localparam int K_CORNER = 1;
    localparam int K_EDGE   = 2;
    localparam int K_CENTRE = 4;

    // Round half up, then divide by the kernel total of 16
    localparam int ROUND_BIAS = 8;
    localparam int SHIFT      = 4;

    // The weighted sum of nine samples (weights total 16) needs four extra bits
    function automatic int sum_width(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/image_blur_stream_line_buffer.sv
// blur_line_buffer: one-row delay line. dout is the word written DEPTH writes ago.
// Contents are not cleared by reset; only the pointer is.
module blur_line_buffer #(
    parameter int DEPTH = 20,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Circular pointer: reading and writing the same slot gives a DEPTH-deep delay
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (we) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Storage write; old contents at ptr are read out before being replaced
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/image_blur_stream.sv
// image_blur_stream: streaming 3x3 Gaussian blur with edge replication.
// Optional macro IMAGE_BLUR_BYPASS_EN adds a per-frame bypass input that
// passes the window centre pixel through unfiltered with identical timing.
//
// Handshake: a pixel is taken on any cycle where in_valid && in_ready;
// in_ready is high only in RUN. out_valid has no back-pressure.
module image_blur_stream
    import image_blur_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int HEIGHT   = 12,
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
`ifdef IMAGE_BLUR_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   image_in,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   image_out,
    output logic                         done,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    localparam int PW         = CHANNELS * DATA_W;
    localparam int NPIX       = WIDTH * HEIGHT;
    localparam int LAST_SHIFT = NPIX + WIDTH;
    localparam int KW         = $clog2(LAST_SHIFT + 2);
    localparam int RW         = $clog2(HEIGHT);
    localparam int CW         = $clog2(WIDTH);
    localparam int SW         = sum_width(DATA_W);

    state_t state, state_nxt;
    logic   start_acc, accept, flushing, shift, emit;

    logic [KW-1:0] k_cnt;
    logic [RW-1:0] out_r;
    logic [CW-1:0] out_c;

    logic [PW-1:0] lb1_dout, lb2_dout;

    // Raw columns: index 0 is the newest (rightmost), index 2 the oldest
    logic [2:0][PW-1:0] raw_top, raw_mid, raw_bot;
    logic               pend_valid, pend_last;
    logic [RW-1:0]      pend_r;
    logic [CW-1:0]      pend_c;

    logic [2:0][1:0]          col_src;
    logic [2:0][2:0][PW-1:0]  clamp_win;
    logic [2:0][2:0][PW-1:0]  win;
    logic                     v1, last1;

    logic [PW-1:0] filt_pix;
    logic          use_bypass;

    assign accept   = in_valid && in_ready;
    assign flushing = (state == FLUSH) && (k_cnt <= KW'(LAST_SHIFT));
    assign shift    = accept || flushing;
    assign emit     = shift && (k_cnt >= KW'(WIDTH + 1));
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, start acceptance and status outputs
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && (k_cnt == KW'(NPIX - 1))) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (v1 && last1) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift counter and coordinates of the next output to be emitted
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            k_cnt <= '0;
            out_r <= '0;
            out_c <= '0;
        end else if (shift) begin
            k_cnt <= k_cnt + 1'b1;
            if (emit) begin
                if (out_c == CW'(WIDTH - 1)) begin
                    out_c <= '0;
                    out_r <= out_r + 1'b1;
                end else begin
                    out_c <= out_c + 1'b1;
                end
            end
        end
    end

    blur_line_buffer #(.DEPTH(WIDTH), .DW(PW)) u_lb1 (
        .clk(clk), .reset(reset), .we(shift), .din(image_in), .dout(lb1_dout)
    );

    blur_line_buffer #(.DEPTH(WIDTH), .DW(PW)) u_lb2 (
        .clk(clk), .reset(reset), .we(shift), .din(lb1_dout), .dout(lb2_dout)
    );

    // Shift a new three-row column into the raw window and tag it with its output coordinate
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= emit;
        end
        if (shift) begin
            raw_top   <= {raw_top[1:0], lb2_dout};
            raw_mid   <= {raw_mid[1:0], lb1_dout};
            raw_bot   <= {raw_bot[1:0], image_in};
            pend_r    <= out_r;
            pend_c    <= out_c;
            pend_last <= (out_r == RW'(HEIGHT - 1)) && (out_c == CW'(WIDTH - 1));
        end
    end

    // Edge replication: out-of-frame neighbours take the centre row/column instead
    always_comb begin
        clamp_win  = '0;
        col_src[0] = (pend_c == '0) ? 2'd1 : 2'd2;
        col_src[1] = 2'd1;
        col_src[2] = (pend_c == CW'(WIDTH - 1)) ? 2'd1 : 2'd0;
        for (int cc = 0; cc < 3; cc++) begin
            clamp_win[1][cc] = raw_mid[col_src[cc]];
            clamp_win[0][cc] = (pend_r == '0) ? raw_mid[col_src[cc]] : raw_top[col_src[cc]];
            clamp_win[2][cc] = (pend_r == RW'(HEIGHT - 1)) ? raw_mid[col_src[cc]]
                                                           : raw_bot[col_src[cc]];
        end
    end

    // Stage 1: register the clamped 3x3 window
    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1    <= pend_valid;
            last1 <= pend_valid && pend_last;
        end
        win <= clamp_win;
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SW-1:0] sum;

        // Weighted 9-tap sum for one channel
        always_comb begin
            sum = SW'(K_CORNER) * SW'(win[0][0][ch*DATA_W +: DATA_W])
                + SW'(K_EDGE)   * SW'(win[0][1][ch*DATA_W +: DATA_W])
                + SW'(K_CORNER) * SW'(win[0][2][ch*DATA_W +: DATA_W])
                + SW'(K_EDGE)   * SW'(win[1][0][ch*DATA_W +: DATA_W])
                + SW'(K_CENTRE) * SW'(win[1][1][ch*DATA_W +: DATA_W])
                + SW'(K_EDGE)   * SW'(win[1][2][ch*DATA_W +: DATA_W])
                + SW'(K_CORNER) * SW'(win[2][0][ch*DATA_W +: DATA_W])
                + SW'(K_EDGE)   * SW'(win[2][1][ch*DATA_W +: DATA_W])
                + SW'(K_CORNER) * SW'(win[2][2][ch*DATA_W +: DATA_W]);
        end

        assign filt_pix[ch*DATA_W +: DATA_W] = DATA_W'((sum + SW'(ROUND_BIAS)) >> SHIFT);
    end

`ifdef IMAGE_BLUR_BYPASS_EN
    logic bypass_q;

    // Bypass mode is captured with start and held for the whole frame
    always_ff @(posedge clk) begin
        if (reset)          bypass_q <= 1'b0;
        else if (start_acc) bypass_q <= bypass;
    end

    assign use_bypass = bypass_q;
`else
    assign use_bypass = 1'b0;
`endif

    // Stage 2: register the rounded result and the end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            image_out <= '0;
        end else begin
            out_valid <= v1;
            done      <= v1 && last1;
            if (v1) image_out <= use_bypass ? win[1][1] : filt_pix;
        end
    end

endmodule

// File: tb/tb_image_blur_stream.sv
// Bench for image_blur_stream: frames are driven with assorted throttling and the
// expected outputs come from a direct clamped-convolution model of each frame.
module tb_image_blur_stream;

    localparam int W     = 20;
    localparam int H     = 12;
    localparam int CH    = 3;
    localparam int DW    = 8;
    localparam int PW    = CH * DW;
    localparam int NPIX  = W * H;
    localparam int EXP_W = PW + 1;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready, out_valid, done, busy;
    logic [PW-1:0] image_in, image_out;
    logic [1:0]    state_dbg;
`ifdef IMAGE_BLUR_BYPASS_EN
    logic          bypass;
`endif

    logic [PW-1:0]    frame_pix [NPIX];
    logic [EXP_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int n_flush  = 0;
    int first_out_cyc = -1;
    int last_acc_cyc  = 0;
    int acc21_cyc     = 0;

    image_blur_stream #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef IMAGE_BLUR_BYPASS_EN
        .bypass(bypass),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .image_in(image_in),
        .out_valid(out_valid),
        .image_out(image_out),
        .done(done),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required end", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // reference model: clamped 3x3 Gaussian straight from the frame array
    function automatic logic [PW-1:0] ref_pixel(input int r, input int c, input bit byp);
        logic [PW-1:0] res;
        int acc, rr, cc, wr, wc;
        res = '0;
        if (byp) return frame_pix[r * W + c];
        for (int ch = 0; ch < CH; ch++) begin
            acc = 0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    rr = r + dr; if (rr < 0) rr = 0; if (rr > H - 1) rr = H - 1;
                    cc = c + dc; if (cc < 0) cc = 0; if (cc > W - 1) cc = W - 1;
                    wr = (dr == 0) ? 2 : 1;
                    wc = (dc == 0) ? 2 : 1;
                    acc += wr * wc * int'(frame_pix[rr * W + cc][ch*DW +: DW]);
                end
            end
            res[ch*DW +: DW] = DW'((acc + 8) / 16);
        end
        return res;
    endfunction

    task automatic push_expected(input bit byp);
        for (int j = 0; j < NPIX; j++)
            exp_q.push_back({(j == NPIX - 1), ref_pixel(j / W, j % W, byp)});
    endtask

    // 0 flat, 1 centre impulse, 2 corner impulse, 3 ramp, 4 random
    task automatic fill_frame(input int pat);
        logic [DW-1:0] v;
        for (int k = 0; k < NPIX; k++) begin
            for (int ch = 0; ch < CH; ch++) begin
                case (pat)
                    0:       v = DW'(8'h40);
                    1:       v = (k == 5 * W + 10) ? DW'(8'hFF) : '0;
                    2:       v = (k == 0) ? DW'(8'hFF) : '0;
                    3:       v = DW'((k * (ch + 1) + ch * 50) % 256);
                    default: v = DW'($urandom_range(0, 255));
                endcase
                frame_pix[k][ch*DW +: DW] = v;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!reset) begin
            if (out_valid) begin
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (cyc > last_acc_cyc + 2) n_flush++;
                check("output_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", 32'(image_out), 32'(e[PW-1:0]));
                    check("done_with_output", 32'(done), 32'(e[PW]));
                    if (e[PW]) check("busy_low_at_done", 32'(busy), 0);
                end
            end else if (done) begin
                check("done_needs_valid", 32'(out_valid), 1);
            end
        end
    end

    // driver tasks
    task automatic start_frame(input bit byp);
`ifdef IMAGE_BLUR_BYPASS_EN
        bypass = byp;
`else
        if (byp) $display("bypass requested without bypass support");
`endif
        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("in_ready_in_run", 32'(in_ready), 1);
    endtask

    task automatic drive_pixels(input int n, input int mode);
        int acc   = 0;
        int guard = 0;
        while (acc < n && guard < 4 * NPIX + 100) begin
            @(negedge clk);
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            image_in = frame_pix[acc];
            if (in_valid && in_ready) begin
                if (acc == W + 1) acc21_cyc = cyc + 1;
                last_acc_cyc = cyc + 1;
                acc++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("accepted_count", 32'(acc), 32'(n));
    endtask

    task automatic finish_frame(input bit chain);
        int waited = 0;
        int rdy_hi = 0;
        bit got    = 1'b0;
        while (!got && waited < 200) begin
            @(negedge clk);
            waited++;
            if (done) begin
                got = 1'b1;
                if (chain) start = 1'b1;
            end else if (in_ready) begin
                rdy_hi++;
            end
        end
        #1;
        check("done_seen", 32'(got), 1);
        check("in_ready_low_in_flush", 32'(rdy_hi), 0);
        check("outputs_per_frame", 32'(n_out), NPIX);
        check("flush_outputs", 32'(n_flush), W + 1);
        check("queue_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic run_frame(input int mode, input bit byp, input bit chain);
        push_expected(byp);
        n_out = 0;
        n_flush = 0;
        first_out_cyc = -1;
        last_acc_cyc = cyc;
        start_frame(byp);
        drive_pixels(NPIX, mode);
        finish_frame(chain);
        if (!chain) begin
            repeat (2) @(negedge clk);
            check("idle_after_done", 32'(state_dbg), 32'(image_blur_pkg::IDLE));
            check("busy_idle", 32'(busy), 0);
        end
    endtask

    // main sequence
    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        image_in = '0;
`ifdef IMAGE_BLUR_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_image_out", 32'(image_out), 0);
        check("reset_done", 32'(done), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_state", 32'(state_dbg), 32'(image_blur_pkg::IDLE));

        fill_frame(0);
        run_frame(0, 1'b0, 1'b0);
        check("first_out_latency", 32'(first_out_cyc - acc21_cyc), 2);

        fill_frame(1);
        run_frame(0, 1'b0, 1'b0);
        fill_frame(2);
        run_frame(0, 1'b0, 1'b0);
        fill_frame(3);
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);

        fill_frame(4);
        run_frame(2, 1'b0, 1'b1);
        fill_frame(4);
        run_frame(0, 1'b0, 1'b0);

        // abandon a frame after 100 accepts
        fill_frame(3);
        push_expected(1'b0);
        n_out = 0;
        last_acc_cyc = cyc;
        start_frame(1'b0);
        drive_pixels(100, 0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_image_out", 32'(image_out), 0);
        repeat (10) @(negedge clk);
        fill_frame(0);
        run_frame(0, 1'b0, 1'b0);

`ifdef IMAGE_BLUR_BYPASS_EN
        fill_frame(3);
        run_frame(0, 1'b1, 1'b0);
        check("bypass_first_out_latency", 32'(first_out_cyc - acc21_cyc), 2);
        run_frame(0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
